mem_access_axi: RTL
===================

// Module: mem_access_axi
// PURPOSE
//  Data-side memory access engine in the M stage; the consumer of the load/store address-error check.
//  Accepts one aligned, error-free load/store per request and runs it as a single-beat AXI read or write.
//  Stalls the pipeline until the access completes, then returns sign/zero-extended load data.
//  Misaligned requests (addr_err=1) never reach the bus; the exception path handles them.
// PARAMETERS
//  SIMUL_AW_W  1  1: AW and W raised in the same cycle; 0: W raised only after the AW handshake
// PORTS
//  clk          in   1   core clock
//  rst          in   1   synchronous, active-high reset
//  mem_req      in   1   M-stage instruction is a load/store
//  addr_err     in   1   OR of laddrerrM/saddrerrM; suppresses the request
//  mem_op       in   6   alucontrolM: LB/LBU/LH/LHU/LW/SB/SH/SW_CONTROL (defines2.vh)
//  mem_addr     in   32  byte address
//  mem_wdata    in   32  raw rt value (unshifted)
//  mem_stall    out  1   hold pipeline stages F..M
//  mem_rdata    out  32  extended load result; valid in the DONE cycle
//  araddr       out  32  AXI read address (= latched mem_addr)
//  arsize       out  3   0 byte / 1 half / 2 word
//  arvalid      out  1   AXI read address valid
//  arready      in   1   AXI read address ready
//  rdata        in   32  AXI read data
//  rvalid       in   1   AXI read data valid
//  rready       out  1   AXI read data ready
//  awaddr       out  32  AXI write address
//  awsize       out  3   same encoding as arsize
//  awvalid      out  1   AXI write address valid
//  awready      in   1   AXI write address ready
//  wdata        out  32  lane-replicated store data
//  wstrb        out  4   byte strobes
//  wvalid       out  1   AXI write data valid
//  wready       in   1   AXI write data ready
//  bvalid       in   1   AXI write response valid
//  bready       out  1   AXI write response ready
// BEHAVIOUR
//  Reset: state=IDLE; all valid/ready outputs 0; mem_rdata=0; latched op, addr and data = 0.
//  FSM states: IDLE, RD_A, RD_D, WR, WR_B, DONE.
//  IDLE: on mem_req & !addr_err, latch op, addr and data.
//    Load -> RD_A. Store -> WR. Otherwise stay in IDLE.
//  Stall: mem_stall = (IDLE & mem_req & !addr_err) | state in {RD_A, RD_D, WR, WR_B}.
//    mem_stall is 0 in DONE; that cycle's edge advances M.
//  RD_A: arvalid=1, held stable until arready. Then -> RD_D.
//  RD_D: rready=1. On rvalid, capture the extended value into mem_rdata, then -> DONE.
//  Load lane select:
//    LB/LBU: byte addr[1:0].
//    LH/LHU: half addr[1].
//    Sign extension for LB/LH only.
//  WR: awvalid and wvalid (wvalid gated per SIMUL_AW_W).
//    Per-channel done flags: each valid drops after its own handshake.
//    Both handshakes may land in the same cycle, or in either order.
//    -> WR_B once both flags are set.
//  WR_B: bready=1. On bvalid -> DONE. bresp is ignored.
//  Store strobes and data:
//    SB: wstrb = 4'b0001 << addr[1:0], wdata = {4{b}}.
//    SH: wstrb = addr[1] ? 4'b1100 : 4'b0011, wdata = {2{h}}.
//    SW: wstrb = 4'hF.
//  DONE: one cycle; mem_rdata stable; then unconditionally -> IDLE. A new request is seen only in IDLE.
//  Latency: best case 3 cycles from accept to DONE.
//  Handshakes: a started transaction always completes; valid never drops before its ready.
//  rst mid-transaction returns to IDLE the same edge, with no bus cleanup.
// STRUCTURE
//  State encoding and size/strobe constants go in defines2.vh, next to the *_CONTROL codes.
//  One sub-module, mem_lane_fmt (combinational): store strobe/data replication and load extract/extend.
// TESTING
//  LW addr 0x1000, arready after 2 cycles, rdata 0x8899AABB -> mem_rdata=0x8899AABB; stall high exactly until DONE.
//  LB addr 0x1003, rdata 0x80FFFFFF -> 0xFFFFFF80. LBU at the same address -> 0x00000080.
//  SH addr 0x2002, rt=0x1234ABCD -> awsize=1, wstrb=1100, wdata=0xABCDABCD; DONE after bvalid.
//  SB addr 0x2001; wready before awready, and a same-cycle aw/w handshake -> each valid drops individually, one B wait.
//  mem_req=1 with addr_err=1 -> no arvalid/awvalid, mem_stall=0.
//  rst asserted in RD_D -> next cycle IDLE, all valids 0, mem_stall=0.

Source files
------------

// File: rtl/mem_access_axi_pkg.sv
// Shared codes for the M-stage memory access engine:
// ALU control codes, FSM states and AXI size encodings.
package mem_access_axi_pkg;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_RD_A,
    ST_RD_D,
    ST_WR,
    ST_WR_B,
    ST_DONE
  } state_t;

  localparam logic [5:0] LB_CONTROL  = 6'h01;
  localparam logic [5:0] LBU_CONTROL = 6'h02;
  localparam logic [5:0] LH_CONTROL  = 6'h03;
  localparam logic [5:0] LHU_CONTROL = 6'h04;
  localparam logic [5:0] LW_CONTROL  = 6'h05;
  localparam logic [5:0] SB_CONTROL  = 6'h06;
  localparam logic [5:0] SH_CONTROL  = 6'h07;
  localparam logic [5:0] SW_CONTROL  = 6'h08;

  localparam logic [2:0] SIZE_B = 3'd0;
  localparam logic [2:0] SIZE_H = 3'd1;
  localparam logic [2:0] SIZE_W = 3'd2;

  function automatic logic is_load(input logic [5:0] op);
    return op inside {LB_CONTROL, LBU_CONTROL,
                      LH_CONTROL, LHU_CONTROL,
                      LW_CONTROL};
  endfunction

  function automatic logic is_store(input logic [5:0] op);
    return op inside {SB_CONTROL, SH_CONTROL,
                      SW_CONTROL};
  endfunction

endpackage

// File: rtl/mem_access_axi_lane_fmt.sv
// Lane formatting: store strobes/replication and
// load lane extract with sign or zero extension.
module mem_lane_fmt
  import mem_access_axi_pkg::*;
(
  input  logic [5:0]  i_op,
  input  logic [1:0]  i_addr,
  input  logic [31:0] i_wdata,
  input  logic [31:0] i_rdata,
  output logic [2:0]  o_size,
  output logic [3:0]  o_wstrb,
  output logic [31:0] o_wdata,
  output logic [31:0] o_rdata
);

  logic [31:0] w_shift;
  logic [7:0]  w_byte;
  logic [15:0] w_half;

  assign w_shift = i_rdata >> {i_addr, 3'b000};
  assign w_byte  = w_shift[7:0];
  assign w_half  = i_addr[1] ? i_rdata[31:16]
                             : i_rdata[15:0];

  always_comb begin
    o_size  = SIZE_W;
    o_wstrb = 4'hF;
    o_wdata = i_wdata;
    o_rdata = i_rdata;
    unique case (1'b1)
      (i_op == LB_CONTROL): begin
        o_size  = SIZE_B;
        o_rdata = {{24{w_byte[7]}}, w_byte};
      end
      (i_op == LBU_CONTROL): begin
        o_size  = SIZE_B;
        o_rdata = {24'h0, w_byte};
      end
      (i_op == LH_CONTROL): begin
        o_size  = SIZE_H;
        o_rdata = {{16{w_half[15]}}, w_half};
      end
      (i_op == LHU_CONTROL): begin
        o_size  = SIZE_H;
        o_rdata = {16'h0, w_half};
      end
      (i_op == SB_CONTROL): begin
        o_size  = SIZE_B;
        o_wstrb = 4'b0001 << i_addr;
        o_wdata = {4{i_wdata[7:0]}};
      end
      (i_op == SH_CONTROL): begin
        o_size  = SIZE_H;
        o_wstrb = i_addr[1] ? 4'b1100 : 4'b0011;
        o_wdata = {2{i_wdata[15:0]}};
      end
      default: ;
    endcase
  end

endmodule

// File: rtl/mem_access_axi.sv
// M-stage data memory engine: one aligned load/store
// per request as a single-beat AXI access, stalling F..M.
module mem_access_axi
  import mem_access_axi_pkg::*;
#(
  parameter bit SIMUL_AW_W = 1'b1
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        mem_req,
  input  logic        addr_err,
  input  logic [5:0]  mem_op,
  input  logic [31:0] mem_addr,
  input  logic [31:0] mem_wdata,
  output logic        mem_stall,
  output logic [31:0] mem_rdata,
  output logic [31:0] araddr,
  output logic [2:0]  arsize,
  output logic        arvalid,
  input  logic        arready,
  input  logic [31:0] rdata,
  input  logic        rvalid,
  output logic        rready,
  output logic [31:0] awaddr,
  output logic [2:0]  awsize,
  output logic        awvalid,
  input  logic        awready,
  output logic [31:0] wdata,
  output logic [3:0]  wstrb,
  output logic        wvalid,
  input  logic        wready,
  input  logic        bvalid,
  output logic        bready
);

  state_t      r_state;
  logic [5:0]  r_op;
  logic [31:0] r_addr;
  logic [31:0] r_wdata;
  logic [31:0] r_rdata;
  logic        r_arvalid;
  logic        r_rready;
  logic        r_awvalid;
  logic        r_wvalid;
  logic        r_bready;
  logic        r_aw_done;
  logic        r_w_done;

  logic        w_accept;
  logic        w_busy;
  logic        w_aw_fin;
  logic        w_w_fin;
  logic [2:0]  w_size;
  logic [3:0]  w_wstrb;
  logic [31:0] w_wdata;
  logic [31:0] w_ext;

  mem_lane_fmt u_fmt (
    .i_op    (r_op),
    .i_addr  (r_addr[1:0]),
    .i_wdata (r_wdata),
    .i_rdata (rdata),
    .o_size  (w_size),
    .o_wstrb (w_wstrb),
    .o_wdata (w_wdata),
    .o_rdata (w_ext)
  );

  assign w_accept = (r_state == ST_IDLE)
                  & mem_req & ~addr_err;
  assign w_busy   = r_state inside {ST_RD_A, ST_RD_D,
                                    ST_WR, ST_WR_B};
  assign mem_stall = w_accept | w_busy;

  // Done flags include a handshake landing this cycle
  assign w_aw_fin = r_aw_done | (r_awvalid & awready);
  assign w_w_fin  = r_w_done | (r_wvalid & wready);

  assign mem_rdata = r_rdata;
  assign araddr    = r_addr;
  assign arsize    = w_size;
  assign arvalid   = r_arvalid;
  assign rready    = r_rready;
  assign awaddr    = r_addr;
  assign awsize    = w_size;
  assign awvalid   = r_awvalid;
  assign wdata     = w_wdata;
  assign wstrb     = w_wstrb;
  assign wvalid    = r_wvalid;
  assign bready    = r_bready;

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state   <= ST_IDLE;
      r_op      <= '0;
      r_addr    <= '0;
      r_wdata   <= '0;
      r_rdata   <= '0;
      r_arvalid <= 1'b0;
      r_rready  <= 1'b0;
      r_awvalid <= 1'b0;
      r_wvalid  <= 1'b0;
      r_bready  <= 1'b0;
      r_aw_done <= 1'b0;
      r_w_done  <= 1'b0;
    end else begin
      unique case (r_state)
        ST_IDLE: begin
          if (w_accept) begin
            r_op      <= mem_op;
            r_addr    <= mem_addr;
            r_wdata   <= mem_wdata;
            r_aw_done <= 1'b0;
            r_w_done  <= 1'b0;
            if (is_load(mem_op)) begin
              r_state   <= ST_RD_A;
              r_arvalid <= 1'b1;
            end else if (is_store(mem_op)) begin
              r_state   <= ST_WR;
              r_awvalid <= 1'b1;
              r_wvalid  <= SIMUL_AW_W;
            end
          end
        end
        ST_RD_A: begin
          if (arready) begin
            r_arvalid <= 1'b0;
            r_rready  <= 1'b1;
            r_state   <= ST_RD_D;
          end
        end
        ST_RD_D: begin
          if (rvalid) begin
            r_rdata  <= w_ext;
            r_rready <= 1'b0;
            r_state  <= ST_DONE;
          end
        end
        ST_WR: begin
          if (r_awvalid && awready) begin
            r_awvalid <= 1'b0;
            r_aw_done <= 1'b1;
          end
          if (r_wvalid && wready) begin
            r_wvalid <= 1'b0;
            r_w_done <= 1'b1;
          end else if (w_aw_fin && !r_w_done
                       && !r_wvalid) begin
            r_wvalid <= 1'b1;
          end
          if (w_aw_fin && w_w_fin) begin
            r_bready <= 1'b1;
            r_state  <= ST_WR_B;
          end
        end
        ST_WR_B: begin
          if (bvalid) begin
            r_bready <= 1'b0;
            r_state  <= ST_DONE;
          end
        end
        ST_DONE: r_state <= ST_IDLE;
        default: r_state <= ST_IDLE;
      endcase
    end
  end

endmodule
